// File: rtl/cpu_pkg.sv
// Shared CPU decode definitions: MIPS32 field positions, opcode constants,
// the instruction-class helper and the decoded-instruction record.
package cpu_pkg;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int IDX_MSB = 25;
    localparam int IDX_LSB = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_e;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  func;
        logic [15:0] imm;
        logic [25:0] index;
        logic [31:0] imm_sext;
        logic [31:0] imm_zext;
        logic [31:0] imm_lui;
        logic        is_rtype;
        logic        is_jtype;
        logic        is_itype;
    } decoded_t;

    // Anything that is not SPECIAL or a jump falls into the I-type bucket,
    // including opcodes the core does not implement.
    function automatic fmt_e classify(input logic [5:0] op);
        fmt_e f;
        f = FMT_I;
        if (op == OP_RTYPE) begin
            f = FMT_R;
        end else if ((op == OP_J) || (op == OP_JAL)) begin
            f = FMT_J;
        end
        return f;
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational MIPS32 field slicer, immediate extender and format classifier.
// Every field is sliced positionally whatever the instruction format.
module instr_fields
    import cpu_pkg::*;
(
    input  logic [31:0] instruction,
    output decoded_t    dec
);

    fmt_e        fmt;
    logic [15:0] imm16;

    always_comb begin
        fmt   = classify(instruction[OP_MSB:OP_LSB]);
        imm16 = instruction[IMM_MSB:IMM_LSB];

        dec          = '0;
        dec.opcode   = instruction[OP_MSB:OP_LSB];
        dec.rs       = instruction[RS_MSB:RS_LSB];
        dec.rt       = instruction[RT_MSB:RT_LSB];
        dec.rd       = instruction[RD_MSB:RD_LSB];
        dec.shamt    = instruction[SH_MSB:SH_LSB];
        dec.func     = instruction[FN_MSB:FN_LSB];
        dec.imm      = imm16;
        dec.index    = instruction[IDX_MSB:IDX_LSB];
        dec.imm_sext = {{16{imm16[15]}}, imm16};
        dec.imm_zext = {16'h0000, imm16};
        dec.imm_lui  = {imm16, 16'h0000};
        dec.is_rtype = (fmt == FMT_R);
        dec.is_jtype = (fmt == FMT_J);
        dec.is_itype = (fmt == FMT_I);
    end

endmodule

// File: rtl/instr_decoder.sv
// Registered MIPS32 instruction decoder for the decode stage: one-cycle latency,
// decoded fields hold their last value while no new instruction arrives.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        in_valid,
    output logic        out_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  func,
    output logic [15:0] imm,
    output logic [25:0] index,
    output logic [31:0] imm_sext,
    output logic [31:0] imm_zext,
    output logic [31:0] imm_lui,
    output logic        is_rtype,
    output logic        is_jtype,
    output logic        is_itype
);

    // Handshake: in_valid marks instruction as capturable on this rising edge;
    // there is no ready, the decoder accepts every cycle. out_valid marks the
    // registered outputs as the decode of an instruction captured last edge.

    decoded_t dec_next;
    decoded_t dec_q;
    logic     valid_q;

    instr_fields u_fields (
        .instruction (instruction),
        .dec         (dec_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                dec_q <= dec_next;
            end
        end
    end

    assign out_valid = valid_q;
    assign opcode    = dec_q.opcode;
    assign rs        = dec_q.rs;
    assign rt        = dec_q.rt;
    assign rd        = dec_q.rd;
    assign shamt     = dec_q.shamt;
    assign func      = dec_q.func;
    assign imm       = dec_q.imm;
    assign index     = dec_q.index;
    assign imm_sext  = dec_q.imm_sext;
    assign imm_zext  = dec_q.imm_zext;
    assign imm_lui   = dec_q.imm_lui;
    assign is_rtype  = dec_q.is_rtype;
    assign is_jtype  = dec_q.is_jtype;
    assign is_itype  = dec_q.is_itype;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: vector table, hold, random stream and
// asynchronous reset sequences, checked through an expected-decode queue.
module tb_instr_decoder;

    localparam int W = 173;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        in_valid;
    logic        out_valid;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [25:0] index;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] imm_lui;
    logic        is_rtype;
    logic        is_jtype;
    logic        is_itype;

    instr_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .in_valid    (in_valid),
        .out_valid   (out_valid),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .func        (func),
        .imm         (imm),
        .index       (index),
        .imm_sext    (imm_sext),
        .imm_zext    (imm_zext),
        .imm_lui     (imm_lui),
        .is_rtype    (is_rtype),
        .is_jtype    (is_jtype),
        .is_itype    (is_itype)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp;
    logic         exp_v;
    logic         chk_en;
    int           checks;
    int           failures;

    logic [W-1:0] act;
    assign act = {opcode, rs, rt, rd, shamt, func, imm, index,
                  imm_sext, imm_zext, imm_lui, is_rtype, is_jtype, is_itype};

    typedef struct {
        string        name;
        logic [31:0]  instr;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [W-1:0] pack(
        input logic [5:0] op, input logic [4:0] f_rs, input logic [4:0] f_rt,
        input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [5:0] f_fn,
        input logic [15:0] f_imm, input logic [25:0] f_idx,
        input logic [31:0] sx, input logic [31:0] zx, input logic [31:0] lu,
        input logic r, input logic j, input logic i);
        return {op, f_rs, f_rt, f_rd, f_sh, f_fn, f_imm, f_idx, sx, zx, lu, r, j, i};
    endfunction

    // Reference decode for random stimulus.
    function automatic logic [W-1:0] model(input logic [31:0] w);
        logic [5:0]  op;
        logic [15:0] i16;
        logic        r;
        logic        j;
        op  = w[31:26];
        i16 = w[15:0];
        r   = (op == 6'h00);
        j   = (op == 6'h02) || (op == 6'h03);
        return pack(op, w[25:21], w[20:16], w[15:11], w[10:6], w[5:0], i16, w[25:0],
                    {{16{i16[15]}}, i16}, {16'h0000, i16}, {i16, 16'h0000},
                    r, j, !(r || j));
    endfunction

    task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    // Expected out_valid: the in_valid seen at the last rising edge, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_v <= 1'b0;
        else        exp_v <= in_valid;
    end

    // Checker: every falling edge compares out_valid, then either the next
    // queued decode or the held previous decode.
    always @(negedge clk) begin
        if (chk_en) begin
            check_bit("out_valid", out_valid, exp_v);
            if (exp_v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL queue_underflow: got decode with no expected entry");
                end else begin
                    last_exp = exp_q.pop_front();
                    check_vec("decode", act, last_exp);
                end
            end else begin
                check_vec("hold", act, last_exp);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [31:0] w, input logic v, input logic [W-1:0] e);
        @(negedge clk);
        instruction = w;
        in_valid    = v;
        if (v) exp_q.push_back(e);
    endtask

    task automatic drive_rand(input logic v);
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[31:26] = 6'($urandom_range(0, 3));
        drive(w, v, model(w));
    endtask

    // ---------------- test ----------------
    initial begin
        checks      = 0;
        failures    = 0;
        chk_en      = 1'b0;
        last_exp    = '0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'h0;

        vecs[0] = '{"ori", 32'h34013456, pack(6'h0D, 5'd0, 5'd1, 5'd6, 5'h11, 6'h16, 16'h3456,
                   26'h0013456, 32'h00003456, 32'h00003456, 32'h34560000, 1'b0, 1'b0, 1'b1)};
        vecs[1] = '{"add", 32'h00221820, pack(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1820,
                   26'h0221820, 32'h00001820, 32'h00001820, 32'h18200000, 1'b1, 1'b0, 1'b0)};
        vecs[2] = '{"addi_neg", 32'h2021FFFF, pack(6'h08, 5'd1, 5'd1, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF,
                   26'h021FFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 1'b1)};
        vecs[3] = '{"jal", 32'h0C100010, pack(6'h03, 5'd0, 5'h10, 5'd0, 5'd0, 6'h10, 16'h0010,
                   26'h0100010, 32'h00000010, 32'h00000010, 32'h00100000, 1'b0, 1'b1, 1'b0)};
        vecs[4] = '{"j", 32'h08000000, pack(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000,
                   26'h0000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0)};
        vecs[5] = '{"lui", 32'h3C01ABCD, pack(6'h0F, 5'd0, 5'd1, 5'h15, 5'h0F, 6'h0D, 16'hABCD,
                   26'h001ABCD, 32'hFFFFABCD, 32'h0000ABCD, 32'hABCD0000, 1'b0, 1'b0, 1'b1)};
        vecs[6] = '{"unknown_op", 32'hFFFFFFFF, pack(6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF,
                   26'h3FFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 1'b1)};

        // Reset state.
        repeat (2) @(negedge clk);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_vec("reset_fields", act, '0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Table vectors, one per cycle with no bubbles.
        for (int i = 0; i < 7; i++) drive(vecs[i].instr, 1'b1, vecs[i].exp);

        // Stall: new word with in_valid low must leave the last decode in place.
        drive(32'h00221820, 1'b0, '0);
        drive(32'h34013456, 1'b0, '0);
        drive(vecs[0].instr, 1'b1, vecs[0].exp);
        drive(vecs[2].instr, 1'b0, '0);

        // Random stream with occasional gaps.
        for (int i = 0; i < 40; i++) drive_rand($urandom_range(0, 3) != 0);

        // Asynchronous reset mid-stream while out_valid is high.
        drive(vecs[1].instr, 1'b1, vecs[1].exp);
        drive(vecs[3].instr, 1'b1, vecs[3].exp);
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        check_bit("pre_reset_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("async_clear_valid", out_valid, 1'b0);
        check_vec("async_clear_fields", act, '0);
        exp_q.delete();
        last_exp = '0;
        in_valid = 1'b1;
        instruction = vecs[5].instr;
        @(negedge clk);
        check_vec("reset_held_fields", act, '0);
        check_bit("reset_held_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // First capture after reset, then a short back-to-back burst.
        drive(vecs[5].instr, 1'b1, vecs[5].exp);
        drive(vecs[2].instr, 1'b1, vecs[2].exp);
        drive(vecs[4].instr, 1'b1, vecs[4].exp);
        repeat (3) drive(32'h0, 1'b0, '0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending decodes expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
